// File: rtl/input_conditioner.sv
// Key conditioning front end: sync + debounce + auto-repeat for moves, gravity tick, blink enable.
// Latency: a clean key edge reaches left/right/rot_final after 2 + DEBOUNCE_CYC cycles; all outputs registered.
// Backpressure: none; rot is held one cycle behind a move, gravity is held until an action-free cycle.
//
// Ports:
//   CLOCK_50                        system clock
//   resetn                          asynchronous reset, active-low
//   key_left_n/key_right_n/key_rot_n raw active-low buttons, asynchronous to CLOCK_50
//   grav_en                         1 = gravity timer runs, 0 = timer and pending tick cleared
//   left_final/right_final/rot_final one-cycle move pulses
//   tick_gravity                    one-cycle gravity step pulse
//   blink_g                         square wave, period 2*BLINK_CYC

// Per-key synchronizer and debouncer.
// Latency: level changes 2 + DEBOUNCE_CYC cycles after a clean raw edge.
// Backpressure: none.
//
// Ports: key_n raw button; level = debounced level in effect this cycle (1 = pressed);
//        held = debounced level of the previous cycle. level & ~held marks a press.
module ic_key_filter #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic level,
    output logic held
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync_a;
    logic          sync_b;
    logic          pressed;
    logic          settle;
    logic [CW-1:0] cnt;

    assign pressed = ~sync_b;

    // Settling is visible as 'level' in the same cycle the register updates,
    // so downstream logic sees the press one cycle earlier than 'held'.
    always_comb begin
        settle = (pressed != held) && (cnt == CW'(DEBOUNCE_CYC - 1));
        level  = settle ? pressed : held;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            cnt    <= '0;
            held   <= 1'b0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            if (pressed == held) begin
                cnt <= '0;
            end else if (settle) begin
                held <= pressed;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// DAS-style auto-repeat for one move direction: IDLE -> DELAY -> REPEAT.
// Latency: fire is combinational from state; first fire in the press cycle, then every REPEAT_RATE after REPEAT_DELAY.
// Backpressure: none; inhibit or a released level forces IDLE without a pulse.
//
// Ports: level/press from the key filter; inhibit = opposite direction also held; fire = move request.
module ic_repeat #(
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic level,
    input  logic press,
    input  logic inhibit,
    output logic fire
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [RW-1:0] cnt;
    logic [RW-1:0] cnt_nxt;

    // The counter is loaded with N-1 and fires on reaching 0, so the gap
    // between two pulses is exactly N cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        if (!level || inhibit) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        fire      = 1'b1;
                        cnt_nxt   = RW'(REPEAT_DELAY - 1);
                        state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (cnt == '0) begin
                        fire      = 1'b1;
                        cnt_nxt   = RW'(REPEAT_RATE - 1);
                        state_nxt = ST_REPEAT;
                    end else begin
                        cnt_nxt = cnt - RW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (cnt == '0) begin
                        fire    = 1'b1;
                        cnt_nxt = RW'(REPEAT_RATE - 1);
                    end else begin
                        cnt_nxt = cnt - RW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

// Top: three key filters, two repeat engines, action arbitration, gravity and blink timers.
// Latency: one register stage after arbitration; key edge to pulse is 2 + DEBOUNCE_CYC cycles.
// Backpressure: none; at most one deferred rot and one deferred gravity tick are held.
module input_conditioner #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int GRAV_CYC     = 25_000_000,
    parameter int BLINK_CYC    = 12_500_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_left_n,
    input  logic key_right_n,
    input  logic key_rot_n,
    input  logic grav_en,
    output logic left_final,
    output logic right_final,
    output logic rot_final,
    output logic tick_gravity,
    output logic blink_g
);
    localparam int GW = (GRAV_CYC > 1) ? $clog2(GRAV_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic lvl_l, held_l, lvl_r, held_r, lvl_rot, held_rot;
    logic press_l, press_r, rot_press;
    logic both_held;
    logic fire_l, fire_r;

    logic          move_any;
    logic          rot_req;
    logic          rot_out;
    logic          rot_pend;
    logic          rot_pend_nxt;
    logic          action;
    logic [GW-1:0] grav_cnt;
    logic          grav_wrap;
    logic          grav_req;
    logic          grav_pend;
    logic          grav_pend_nxt;
    logic          tick_nxt;
    logic [BW-1:0] blink_cnt;

    ic_key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_left (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key_n    (key_left_n),
        .level    (lvl_l),
        .held     (held_l)
    );

    ic_key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_right (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key_n    (key_right_n),
        .level    (lvl_r),
        .held     (held_r)
    );

    ic_key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_rot (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key_n    (key_rot_n),
        .level    (lvl_rot),
        .held     (held_rot)
    );

    assign press_l   = lvl_l & ~held_l;
    assign press_r   = lvl_r & ~held_r;
    assign rot_press = lvl_rot & ~held_rot;

    // Holding both directions cancels both; a still-held key needs a new
    // press edge afterwards because IDLE only leaves on press.
    assign both_held = lvl_l & lvl_r;

    ic_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_left (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .level    (lvl_l),
        .press    (press_l),
        .inhibit  (both_held),
        .fire     (fire_l)
    );

    ic_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_right (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .level    (lvl_r),
        .press    (press_r),
        .inhibit  (both_held),
        .fire     (fire_r)
    );

    // Rot yields to a move; one rot can wait. Gravity yields to any action
    // and its pending flag carries it to the first quiet cycle.
    always_comb begin
        move_any      = fire_l | fire_r;
        rot_req       = rot_press | rot_pend;
        rot_out       = rot_req & ~move_any;
        rot_pend_nxt  = rot_req & move_any;
        action        = move_any | rot_out;
        grav_wrap     = grav_en && (grav_cnt == GW'(GRAV_CYC - 1));
        grav_req      = grav_pend | grav_wrap;
        tick_nxt      = grav_en & grav_req & ~action;
        grav_pend_nxt = grav_en & grav_req & action;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            grav_cnt <= '0;
        end else if (!grav_en || grav_wrap) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + GW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink_g   <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink_g   <= ~blink_g;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rot_pend     <= 1'b0;
            grav_pend    <= 1'b0;
            left_final   <= 1'b0;
            right_final  <= 1'b0;
            rot_final    <= 1'b0;
            tick_gravity <= 1'b0;
        end else begin
            rot_pend     <= rot_pend_nxt;
            grav_pend    <= grav_pend_nxt;
            left_final   <= fire_l;
            right_final  <= fire_r;
            rot_final    <= rot_out;
            tick_gravity <= tick_nxt;
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with scaled timing parameters.
// Expected outputs come from a cycle-level behavioural model fed by the same inputs.
// A monitor pops one expected output word per clock and compares.
module tb_input_conditioner;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam int GC  = 16;
    localparam int BC  = 5;

    logic CLOCK_50    = 1'b0;
    logic resetn      = 1'b0;
    logic key_left_n  = 1'b1;
    logic key_right_n = 1'b1;
    logic key_rot_n   = 1'b1;
    logic grav_en     = 1'b0;
    logic left_final, right_final, rot_final, tick_gravity, blink_g;

    input_conditioner #(
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .GRAV_CYC     (GC),
        .BLINK_CYC    (BC)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .key_left_n   (key_left_n),
        .key_right_n  (key_right_n),
        .key_rot_n    (key_rot_n),
        .grav_en      (grav_en),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity),
        .blink_g      (blink_g)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    // ---------------- behavioural reference model ----------------
    // Key: the debouncer sees the raw key two clocks late; the level flips once
    // the last DEB synchronized samples all disagree with it.
    // Moves: pulse at the press, then at hold times RD, RD+RR, RD+2RR ...
    bit         m_raw1[3];
    bit         m_raw2[3];
    bit [DEB-1:0] m_hist[3];
    bit         m_lvl[3];
    int         m_p[2];
    bit         m_pv[2];
    bit         m_rpend, m_gpend;
    int         m_gc, m_n;

    always @(posedge CLOCK_50) begin : model
        bit raw_now[3];
        bit press[3];
        bit mv[2];
        bit s, nl, both, rot_o, act, wrap, tick, blink;
        int d;
        raw_now[0] = key_left_n;
        raw_now[1] = key_right_n;
        raw_now[2] = key_rot_n;
        if (!resetn) begin
            for (int k = 0; k < 3; k++) begin
                m_raw1[k] = 1'b1;
                m_raw2[k] = 1'b1;
                m_hist[k] = '0;
                m_lvl[k]  = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                m_pv[k] = 1'b0;
                m_p[k]  = 0;
            end
            m_rpend = 1'b0;
            m_gpend = 1'b0;
            m_gc    = 0;
            m_n     = 0;
        end else begin
            m_n++;
            for (int k = 0; k < 3; k++) begin
                s         = ~m_raw2[k];
                m_raw2[k] = m_raw1[k];
                m_raw1[k] = raw_now[k];
                m_hist[k] = {m_hist[k][DEB-2:0], s};
                nl        = m_lvl[k];
                if (m_hist[k] == {DEB{~m_lvl[k]}}) nl = s;
                press[k]  = nl & ~m_lvl[k];
                m_lvl[k]  = nl;
            end
            both = m_lvl[0] & m_lvl[1];
            for (int k = 0; k < 2; k++) begin
                if (!m_lvl[k] || both) begin
                    m_pv[k] = 1'b0;
                    mv[k]   = 1'b0;
                end else if (press[k]) begin
                    m_pv[k] = 1'b1;
                    m_p[k]  = m_n;
                    mv[k]   = 1'b1;
                end else if (m_pv[k]) begin
                    d     = m_n - m_p[k];
                    mv[k] = (d >= RD) && (((d - RD) % RR) == 0);
                end else begin
                    mv[k] = 1'b0;
                end
            end
            rot_o   = !(mv[0] | mv[1]) && (m_rpend | press[2]);
            m_rpend = (mv[0] | mv[1]) && (m_rpend | press[2]);
            act     = mv[0] | mv[1] | rot_o;
            wrap    = grav_en && ((m_gc % GC) == GC - 1);
            tick    = grav_en && (m_gpend | wrap) && !act;
            m_gpend = grav_en && (m_gpend | wrap) && act;
            m_gc    = grav_en ? m_gc + 1 : 0;
            blink   = ((m_n / BC) % 2) == 1;
            exp_q.push_back({mv[0], mv[1], rot_o, tick, blink});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0;
    int n_left = 0, n_right = 0, n_rot = 0;
    int t_left_last = -1, t_rot_last = -1;
    int t_right[$];
    int t_tick[$];

    always @(negedge CLOCK_50) begin : monitor
        logic [4:0] got, expv;
        got = {left_final, right_final, rot_final, tick_gravity, blink_g};
        if (!resetn) begin
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got l/r/rot/tick/blink=%b, expected 00000", got);
            end
            exp_q.delete();
            cyc = 0;
        end else begin
            cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow cyc=%0d: got %b, expected an entry", cyc, got);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got l/r/rot/tick/blink=%b, expected %b", cyc, got, expv);
                end
            end
            if (left_final === 1'b1) begin n_left++; t_left_last = cyc; end
            if (right_final === 1'b1) begin n_right++; t_right.push_back(cyc); end
            if (rot_final === 1'b1) begin n_rot++; t_rot_last = cyc; end
            if (tick_gravity === 1'b1) t_tick.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            #2;
        end
    endtask

    task automatic check_eq(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    initial begin : stim
        int c0, base_l, base_r, base_rot;
        tick_n(3);

        // Gravity from reset with a left press landing on the first wrap.
        t_tick.delete();
        resetn  = 1'b1;
        grav_en = 1'b1;
        tick_n(10);
        key_left_n = 1'b0;
        tick_n(6);
        key_left_n = 1'b1;
        tick_n(30);
        check_eq("left_on_wrap_time", t_left_last, 16);
        check_eq("tick_count_after_reset", (t_tick.size() >= 2) ? 2 : t_tick.size(), 2);
        if (t_tick.size() >= 2) begin
            check_eq("first_tick_deferred", t_tick[0], 17);
            check_eq("second_tick_spacing", t_tick[1], 32);
        end

        // Glitchy left, then stable low.
        base_l = n_left;
        for (int g = 0; g < 2; g++) begin
            key_left_n = 1'b0; tick_n(2);
            key_left_n = 1'b1; tick_n(2);
        end
        check_eq("glitch_no_pulse", n_left - base_l, 0);
        c0 = cyc;
        key_left_n = 1'b0;
        tick_n(10);
        key_left_n = 1'b1;
        tick_n(20);
        check_eq("debounced_left_count", n_left - base_l, 1);
        check_eq("debounced_left_latency", t_left_last - c0, 6);

        // Right held 60 cycles: auto-repeat schedule.
        t_right.delete();
        c0 = cyc;
        key_right_n = 1'b0;
        tick_n(60);
        key_right_n = 1'b1;
        tick_n(30);
        check_eq("right_repeat_count", t_right.size(), 6);
        if (t_right.size() >= 6) begin
            check_eq("right_first_latency", t_right[0] - c0, 6);
            for (int i = 1; i < 6; i++)
                check_eq($sformatf("right_gap_%0d", i), t_right[i] - t_right[i-1], (i == 1) ? RD : RR);
        end

        // Rot held: no repeat. Then rot and left pressed together.
        base_rot = n_rot;
        key_rot_n = 1'b0;
        tick_n(60);
        key_rot_n = 1'b1;
        tick_n(20);
        check_eq("rot_hold_count", n_rot - base_rot, 1);
        key_rot_n  = 1'b0;
        key_left_n = 1'b0;
        tick_n(8);
        key_rot_n  = 1'b1;
        key_left_n = 1'b1;
        tick_n(20);
        check_eq("rot_after_left_gap", t_rot_last - t_left_last, 1);

        // Both directions held, then right released while left stays held.
        base_l = n_left;
        base_r = n_right;
        key_left_n  = 1'b0;
        key_right_n = 1'b0;
        tick_n(40);
        check_eq("both_held_pulses", (n_left - base_l) + (n_right - base_r), 0);
        key_right_n = 1'b1;
        tick_n(30);
        check_eq("left_no_resume", n_left - base_l, 0);
        key_left_n = 1'b1;
        tick_n(10);
        key_left_n = 1'b0;
        tick_n(8);
        key_left_n = 1'b1;
        tick_n(20);
        check_eq("left_repress", n_left - base_l, 1);

        // Randomized key and gravity activity.
        for (int it = 0; it < 40; it++) begin
            key_left_n  = ($urandom_range(0, 2) != 0);
            key_right_n = ($urandom_range(0, 2) != 0);
            key_rot_n   = ($urandom_range(0, 2) != 0);
            grav_en     = ($urandom_range(0, 4) != 0);
            tick_n($urandom_range(1, 40));
        end
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        key_rot_n   = 1'b1;
        grav_en     = 1'b1;
        tick_n(20);

        // Async reset while right is auto-repeating and blink is high.
        key_right_n = 1'b0;
        tick_n(40);
        for (int i = 0; i < 12 && blink_g !== 1'b1; i++) tick_n(1);
        check_eq("blink_high_before_reset", int'(blink_g === 1'b1), 1);
        resetn = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 int'({left_final, right_final, rot_final, tick_gravity, blink_g}), 0);
        key_right_n = 1'b1;
        tick_n(3);
        t_tick.delete();
        base_l = n_left;
        base_r = n_right;
        base_rot = n_rot;
        resetn = 1'b1;
        tick_n(40);
        check_eq("post_reset_first_tick", (t_tick.size() > 0) ? t_tick[0] : -1, 16);
        check_eq("post_reset_no_moves", (n_left - base_l) + (n_right - base_r) + (n_rot - base_rot), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
